// File: rtl/mem_lsu_if.sv
// Request/response and data-memory signal bundle for mem_lsu.
// master = pipeline/memory environment side, slave = the load/store unit.
interface mem_lsu_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        oob;
  logic [31:0] mem_dir;
  logic [31:0] mem_datain;
  logic        mem_writes;
  logic        mem_reads;
  logic [31:0] mem_dataout;

  modport master (
    output req, we, size, unsigned_ld, addr, wdata, mem_dataout,
    input  busy, done, rdata, misalign, oob,
    input  mem_dir, mem_datain, mem_writes, mem_reads
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata, mem_dataout,
    output busy, done, rdata, misalign, oob,
    output mem_dir, mem_datain, mem_writes, mem_reads
  );
endinterface

// File: rtl/mem_lsu.sv
// Byte-addressed load/store unit in front of a word-addressed data memory.
// Optional LSU_COUNT_EN adds saturating completed-load/store counters.
module mem_lsu #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_lsu_if.slave   bus
`ifdef LSU_COUNT_EN
  ,
  output logic [15:0] ld_count,
  output logic [15:0] st_count
`endif
);

  // state  | meaning
  // IDLE   | waiting for req
  // ERR    | misaligned / out-of-range request, done with error flags
  // RD     | load read cycle, lane extracted at end
  // RMW_RD | sub-word store reads the old word
  // WR     | memory write cycle, dir/datain held from registers
  // DONE   | completion pulse
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERR    = 3'd1,
    RD     = 3'd2,
    RMW_RD = 3'd3,
    WR     = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] WORDS_L = (ADDR_W+1)'(MEM_WORDS);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W+1:0] addr_q;
  logic [15:0]       wlo_q;
  logic              mis_q;
  logic              oob_q;
  logic [31:0]       rdata_q;
  logic [31:0]       datain_q;
  logic              mis_in;
  logic              oob_in;
  logic              accept;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [15:0] wlo,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wlo[7:0];
        2'd1:    r[15:8]  = wlo[7:0];
        2'd2:    r[23:16] = wlo[7:0];
        default: r[31:24] = wlo[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = wlo;
    end else begin
      r[15:0] = wlo;
    end
    return r;
  endfunction

  always_comb begin
    mis_in = (bus.size == 2'b11) ||
             (bus.size == 2'b01 && bus.addr[0]) ||
             (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    oob_in = (bus.addr[31:ADDR_W+2] != '0) ||
             ({1'b0, bus.addr[ADDR_W+1:2]} >= WORDS_L);
  end

  assign accept = (state == IDLE) && bus.req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (mis_in || oob_in)      state_nx = ERR;
          else if (!bus.we)          state_nx = RD;
          else if (bus.size == 2'b10) state_nx = WR;
          else                       state_nx = RMW_RD;
        end
      end
      ERR:     state_nx = IDLE;
      RD:      state_nx = DONE;
      RMW_RD:  state_nx = WR;
      WR:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write data is fully formed one edge before WR so the memory sees it stable all cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q   <= '0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wlo_q    <= '0;
      mis_q    <= 1'b0;
      oob_q    <= 1'b0;
      rdata_q  <= '0;
      datain_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            size_q <= bus.size;
            uns_q  <= bus.unsigned_ld;
            addr_q <= bus.addr[ADDR_W+1:0];
            wlo_q  <= bus.wdata[15:0];
            mis_q  <= mis_in;
            oob_q  <= oob_in;
            if (bus.we) datain_q <= bus.wdata;
          end
        end
        RD:      rdata_q  <= extract(bus.mem_dataout, size_q, addr_q[1:0], uns_q);
        RMW_RD:  datain_q <= merge(bus.mem_dataout, wlo_q, size_q, addr_q[1:0]);
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == ERR) || (state == DONE);
  assign bus.misalign   = (state == ERR) && mis_q;
  assign bus.oob        = (state == ERR) && oob_q;
  assign bus.mem_reads  = (state == RD) || (state == RMW_RD);
  assign bus.mem_writes = (state == WR);
  assign bus.mem_dir    = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign bus.mem_datain = datain_q;
  assign bus.rdata      = rdata_q;

`ifdef LSU_COUNT_EN
  logic we_q;

  // DONE is only reached by accesses that passed the error checks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      ld_count <= '0;
      st_count <= '0;
    end else begin
      if (accept) we_q <= bus.we;
      if (state == DONE) begin
        if (we_q) begin
          if (st_count != 16'hFFFF) st_count <= st_count + 16'd1;
        end else begin
          if (ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
        end
      end
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed table, req-held and reset-in-WR sequences,
// then random traffic against a word-array reference model.
module tb_mem_lsu;
  logic clk;
  logic rst_n;
  logic clr;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int n_checks;
  int n_err;
  int ld_n;
  int st_n;
  logic [31:0] last_rdata;

  mem_lsu_if bus();

`ifdef LSU_COUNT_EN
  logic [15:0] ld_count;
  logic [15:0] st_count;
  mem_lsu #(.MEM_WORDS(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ld_count(ld_count), .st_count(st_count));
`else
  mem_lsu #(.MEM_WORDS(32), .ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level-sensitive write memory, sampled at the end of the write cycle.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (bus.mem_writes) begin
      mem[bus.mem_dir[4:0]] <= bus.mem_datain;
    end
  end
  assign bus.mem_dataout = mem[bus.mem_dir[4:0]];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
    logic        oob;
    int          lat;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [31:0] a, input logic u);
    int sh;
    logic [31:0] v;
    sh = 8 * int'(a % 4);
    if (sz == 2'd0) begin
      v = (word >> sh) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (word >> sh) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] old, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    sh = 8 * int'(a % 4);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic run_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_mis,
                         input logic exp_oob, input int exp_lat);
    logic err;
    int idx;
    logic [31:0] new_word;
    int lat;
    bit got, rd_seen, wr_seen, bad;
    err = exp_mis | exp_oob;
    idx = int'(a[6:2]);
    new_word = st_model(ref_mem[idx], sz, a, wd);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.unsigned_ld = u; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req = 1'b0; bus.addr = $urandom; bus.wdata = $urandom;
    bus.size = 2'($urandom_range(0, 3)); bus.we = 1'($urandom_range(0, 1));
    bus.unsigned_ld = 1'($urandom_range(0, 1));
    lat = 0; got = 0; rd_seen = 0; wr_seen = 0; bad = 0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.mem_reads) begin
        rd_seen = 1;
        if (bus.mem_dir != 32'(idx)) bad = 1;
      end
      if (bus.mem_writes) begin
        wr_seen = 1;
        if (bus.mem_dir != 32'(idx) || bus.mem_datain != new_word || bus.mem_reads) bad = 1;
      end
      if (bus.done) got = 1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("misalign", 32'(bus.misalign), 32'(exp_mis));
    chk("oob", 32'(bus.oob), 32'(exp_oob));
    if (!w && !err) begin
      chk("rdata", bus.rdata, exp_rd);
      last_rdata = exp_rd;
    end else begin
      chk("rdata_kept", bus.rdata, last_rdata);
    end
    chk("reads_used", 32'(rd_seen), 32'(!err && (!w || sz != 2'd2)));
    chk("writes_used", 32'(wr_seen), 32'(!err && w));
    chk("mem_side", 32'(bad), 32'd0);
    if (!err) begin
      if (w) begin
        ref_mem[idx] = new_word;
        st_n++;
      end else begin
        ld_n++;
      end
    end
    @(negedge clk);
    chk("done_pulse", {30'd0, bus.done, bus.busy}, 32'd0);
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic w, u, mis, oob;
    logic [1:0] sz;
    logic [31:0] a, wd, rd;
    int lat;
    logic [5:0] busy_v, done_v;
    n_checks = 0; n_err = 0; ld_n = 0; st_n = 0; last_rdata = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h04, 32'h0000006E, 32'h0,        1'b0, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h0000006E, 1'b0, 1'b0, 2};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h06, 32'h00000080, 32'h0,        1'b0, 1'b0, 3};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h06, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 2};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h06, 32'h0,        32'h00000080, 1'b0, 1'b0, 2};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        32'h0080006E, 1'b0, 1'b0, 2};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h04, 32'h0000006E, 32'h0,        1'b0, 1'b0, 2};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h06, 32'h1234BEEF, 32'h0,        1'b0, 1'b0, 3};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h06, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0, 2};
    tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h06, 32'h0,        32'h0000BEEF, 1'b0, 1'b0, 2};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 32'h07, 32'h0,        32'hFFFFFFBE, 1'b0, 1'b0, 2};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 32'h04, 32'h0,        32'h0000006E, 1'b0, 1'b0, 2};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1};
    tbl[14] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    tbl[15] = '{1'b0, 2'd1, 1'b0, 32'h83, 32'h0,        32'h0,        1'b1, 1'b1, 1};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 32'h01, 32'h0000FFFF, 32'h0,        1'b1, 1'b0, 1};
    tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h7C, 32'h0,        32'h00000000, 1'b0, 1'b0, 2};
    tbl[18] = '{1'b1, 2'd0, 1'b0, 32'h7F, 32'h000000A5, 32'h0,        1'b0, 1'b0, 3};
    tbl[19] = '{1'b0, 2'd0, 1'b0, 32'h7F, 32'h0,        32'hFFFFFFA5, 1'b0, 1'b0, 2};

    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.unsigned_ld = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    rst_n = 1'b0; clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("rst_flags", {30'd0, bus.misalign, bus.oob}, 32'd0);
    chk("rst_mem_en", {30'd0, bus.mem_reads, bus.mem_writes}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_mem_dir", bus.mem_dir, 32'd0);
    chk("rst_mem_datain", bus.mem_datain, 32'd0);
    rst_n = 1'b1; clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++)
      run_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, tbl[i].rd,
              tbl[i].mis, tbl[i].oob, tbl[i].lat);

    // req held high through a load: second accept only in the IDLE cycle after done
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.unsigned_ld = 1'b0;
    bus.addr = 32'h04; bus.wdata = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      busy_v[i] = bus.busy;
      done_v[i] = bus.done;
      if (i == 4) bus.req = 1'b0;
    end
    chk("held_busy", 32'(busy_v), 32'b011011);
    chk("held_done", 32'(done_v), 32'b010010);
    chk("held_rdata", bus.rdata, ref_mem[1]);
    last_rdata = ref_mem[1];
    ld_n += 2;

    for (int i = 0; i < 150; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
      wd = $urandom;
      mis = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
      oob = (a / 4) >= 32;
      lat = (mis || oob) ? 1 : (w && sz != 2'd2) ? 3 : 2;
      rd  = ld_model(ref_mem[a[6:2]], sz, a, u);
      run_req(w, sz, u, a, wd, rd, mis, oob, lat);
    end

    // reset asserted during the write cycle of a byte store
    run_req(1'b1, 2'd2, 1'b0, 32'h0C, 32'h11223344, 32'h0, 1'b0, 1'b0, 2);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.unsigned_ld = 1'b0;
    bus.addr = 32'h0D; bus.wdata = 32'h000000CC;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    #2;
    chk("rmw_in_wr", 32'(bus.mem_writes), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr", {29'd0, bus.mem_writes, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rdata_again", bus.rdata, 32'd0);
    chk("rst_word_whole", 32'(mem[3] == 32'h11223344 || mem[3] == 32'h1122CC44), 32'd1);
    ref_mem[3] = mem[3];
    last_rdata = '0; ld_n = 0; st_n = 0;
`ifdef LSU_COUNT_EN
    chk("rst_counts", {ld_count, st_count}, 32'd0);
`endif
    run_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, ref_mem[3], 1'b0, 1'b0, 2);

    for (int i = 0; i < 30; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      u  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 131));
      wd = $urandom;
      mis = (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
      oob = (a / 4) >= 32;
      lat = (mis || oob) ? 1 : (w && sz != 2'd2) ? 3 : 2;
      rd  = ld_model(ref_mem[a[6:2]], sz, a, u);
      run_req(w, sz, u, a, wd, rd, mis, oob, lat);
    end

`ifdef LSU_COUNT_EN
    chk("ld_count", 32'(ld_count), 32'(ld_n));
    chk("st_count", 32'(st_count), 32'(st_n));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit sitting directly upstream of the word-addressed data memory (`mem_dir`/`mem_datain`/`mem_writes`/`mem_reads`/`mem_dataout` interface).
- Accepts byte-addressed load/store requests from the MEM pipeline stage.
- Converts them to word accesses and performs read-modify-write for byte/halfword stores.
- Sign/zero-extends loads and flags misaligned or out-of-range accesses.
- Handshake: req in, busy/done out.

Parameters:
MEM_WORDS, 32, number of 32-bit words in the data memory
ADDR_W, 5, word-index width; must equal clog2(MEM_WORDS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  request strobe, sampled only in IDLE
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
unsigned_ld  in  1  1=zero-extend sub-word load, 0=sign-extend
addr  in  32  byte address
wdata  in  32  store data, right-aligned
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
rdata  out  32  load result, valid when done=1 and not errored
misalign  out  1  valid with done; alignment or size error
oob  out  1  valid with done; word index >= MEM_WORDS
mem_dir  out  32  word index to memory, zero-extended {addr[ADDR_W+1:2]}
mem_datain  out  32  write data to memory
mem_writes  out  1  memory write enable
mem_reads  out  1  memory read enable
mem_dataout  in  32  memory read data (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, misalign, oob, mem_writes, mem_reads = 0.
  - rdata, mem_dir, mem_datain = 0.
  - Reset mid-operation aborts immediately; mem_writes drops asynchronously; memory contents already written stay.
- IDLE, req=1 at edge: latch we, size, unsigned_ld, addr, wdata; evaluate errors from latched values.
  - misalign: size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - oob: addr[31:ADDR_W+2] != 0.
  - Any error -> ERR. Load -> RD. Word store -> WR. Sub-word store -> RMW_RD.
- ERR: done=1 with misalign/oob (both may be 1); rdata unchanged; mem_reads=mem_writes=0 -> IDLE.
- RD: mem_reads=1, mem_dir stable. At edge, extract lane and extend into rdata -> DONE.
  - Byte lanes little-endian: addr[1:0]=0 is bits 7:0; halfword addr[1]=0 is bits 15:0.
- RMW_RD: mem_reads=1; at edge capture mem_dataout into old-word register -> WR.
- WR: mem_writes=1, mem_reads=0.
  - mem_datain = wdata (word store), or old word with the selected lane replaced by wdata[7:0]/wdata[15:0].
  - mem_dir and mem_datain must be stable the whole WR cycle (memory writes level-sensitive) -> DONE.
- DONE: done=1, misalign=oob=0 -> IDLE.
- All memory-side and handshake outputs are decoded from registered state/registers only; no combinational path from req/addr to mem_writes.
- Latency from the req-accept edge to the done cycle:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput: next req accepted in the cycle after done, i.e. the IDLE cycle. req while busy is ignored, not queued.
- mem_reads and mem_writes are never both 1.

Optional Feature:
Macro LSU_COUNT_EN.
- Defined: adds outputs ld_count[15:0] and st_count[15:0].
  - Each increments on done for a non-errored load/store respectively.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Memory word1=0x0000006E; LW addr 0x4 -> done 2 cycles after accept, rdata=0x0000006E, misalign=oob=0, mem_writes never high.
- SB wdata=0x80 addr 0x6 (word1=0x0000006E) -> RMW_RD, WR, DONE; word1=0x0080006E. Then LB addr 0x6 -> rdata=0xFFFFFF80; LBU -> 0x00000080.
- SH wdata=0x1234BEEF addr 0x6 on word1=0x0000006E -> word1=0xBEEF006E; LH addr 0x6 -> 0xFFFFBEEF.
- Error requests, no memory access:
  - LW addr 0x2 -> done 1 cycle after accept, misalign=1, oob=0, mem_reads/mem_writes stay 0.
  - SW addr 0x80 -> oob=1, memory unchanged.
  - size=11 -> misalign=1.
- Assert rst_n=0 during WR of an SB -> mem_writes falls immediately, busy=0, done=0. After release, LW of the same word returns either the old or the fully merged value, never a partial lane.
- req held high through a load -> second request accepted only in the IDLE cycle after done. With LSU_COUNT_EN: 3 loads + 2 stores + 1 error -> ld_count=3, st_count=2.
